// File: rtl/juggle_pkg.sv
// juggle_pkg: shared constants and types for the siteswap throw scheduler.
//   MAX_LEN       - maximum pattern length / digits in the pattern bus
//   MAX_HEIGHT    - maximum throw height; landing queue holds MAX_HEIGHT+1 slots
//   slot_t        - one landing-queue entry {valid, ball id}
//   sched_state_t - scheduler FSM states
package juggle_pkg;
    localparam int MAX_LEN = 7;
    localparam int MAX_HEIGHT = 7;
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } slot_t;
    typedef enum logic [1:0] {IDLE, RUN, ERROR} sched_state_t;
endpackage

// File: rtl/landing_queue.sv
// landing_queue: slot[k] holds the ball landing k beats from now.
//   clk, rst        - clock, async active-high reset
//   clear           - empty every slot
//   shift           - advance one beat (slot[i] <= slot[i+1], top empties)
//   wr_en/wr_idx/wr_id - on a shift, place a ball at the post-shift index
//   head            - slot[0], the ball landing this beat
//   rd_idx/rd_slot  - combinational read of the pre-shift slot[rd_idx]
module landing_queue
    import juggle_pkg::*;
#(
    parameter int DEPTH = MAX_HEIGHT + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          shift,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [2:0]    wr_id,
    input  logic [AW-1:0] rd_idx,
    output slot_t         head,
    output slot_t         rd_slot
);
    slot_t slot [DEPTH];
    assign head = slot[0];
    assign rd_slot = slot[rd_idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            slot <= '{default: '0};
        end else if (shift) begin
            for (int i = 0; i < DEPTH - 1; i++) slot[i] <= slot[i+1];
            slot[DEPTH-1] <= '0;
            // later NBA wins: the thrown ball overrides the shifted entry
            if (wr_en) slot[wr_idx] <= '{valid: 1'b1, id: wr_id};
        end
    end
endmodule

// File: rtl/juggle_scheduler.sv
// juggle_scheduler: beat-driven siteswap throw scheduler.
//   clk_in, rst_in       - clock, async active-high reset
//   new_beat             - single-cycle beat strobe
//   pattern_in           - siteswap digits, index 0 thrown first
//   pattern_length       - digits in use (1..MAX_LEN)
//   num_balls_in         - ball count
//   pattern_valid_in     - level, pattern is valid; low returns to IDLE
//   throw_valid_out      - one-cycle pulse per throw
//   throw_ball_out/throw_height_out - ball id and height of the last throw
//   hand_out             - hand of the last scheduled beat (0 right, 1 left)
//   beat_index_out       - pattern position of the last scheduled beat
//   running_out/error_out - high in RUN / ERROR
module juggle_scheduler #(
    parameter int MAX_LEN = juggle_pkg::MAX_LEN,
    parameter int MAX_HEIGHT = juggle_pkg::MAX_HEIGHT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  new_beat,
    input  logic [MAX_LEN-1:0][2:0] pattern_in,
    input  logic [2:0]            pattern_length,
    input  logic [2:0]            num_balls_in,
    input  logic                  pattern_valid_in,
    output logic                  throw_valid_out,
    output logic [2:0]            throw_ball_out,
    output logic [2:0]            throw_height_out,
    output logic                  hand_out,
    output logic [2:0]            beat_index_out,
    output logic                  running_out,
    output logic                  error_out
);
    import juggle_pkg::*;
    sched_state_t state;
    logic [MAX_LEN-1:0][2:0] pat;
    logic [2:0] len, num, launched, beat_idx, h, wr_id;
    logic hand, throw_ok, err, beat_go, shift, wr_en;
    slot_t head, at_h;
    always_comb begin
        h = pat[beat_idx];
        throw_ok = h != 3'd0 && (head.valid || launched < num);
        // collision on a zero beat, starvation, or landing on an occupied slot
        err = (h == 3'd0) ? head.valid : ((!head.valid && launched == num) || at_h.valid);
        beat_go = state == RUN && pattern_valid_in && new_beat;
        shift = beat_go && !err;
        wr_en = shift && throw_ok;
        wr_id = head.valid ? head.id : launched;
    end
    landing_queue #(.DEPTH(MAX_HEIGHT + 1)) u_queue (
        .clk(clk_in),
        .rst(rst_in),
        .clear(!pattern_valid_in),
        .shift(shift),
        .wr_en(wr_en),
        .wr_idx(h - 3'd1),
        .wr_id(wr_id),
        .rd_idx(h),
        .head(head),
        .rd_slot(at_h)
    );
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            pat <= '0;
            {len, num, launched, beat_idx, hand} <= '0;
            {throw_valid_out, throw_ball_out, throw_height_out, hand_out} <= '0;
            {beat_index_out, running_out, error_out} <= '0;
        end else if (state != IDLE && !pattern_valid_in) begin
            state <= IDLE;
            {launched, beat_idx, hand} <= '0;
            {throw_valid_out, throw_ball_out, throw_height_out, hand_out} <= '0;
            {beat_index_out, running_out, error_out} <= '0;
        end else begin
            throw_valid_out <= 1'b0;
            case (state)
                IDLE: if (pattern_valid_in && pattern_length != 3'd0) begin
                    pat <= pattern_in;
                    len <= pattern_length;
                    num <= num_balls_in;
                    state <= RUN;
                    running_out <= 1'b1;
                end
                RUN: if (beat_go) begin
                    if (err) begin
                        state <= ERROR;
                        running_out <= 1'b0;
                        error_out <= 1'b1;
                    end else begin
                        throw_valid_out <= throw_ok;
                        if (throw_ok) begin
                            throw_ball_out <= wr_id;
                            throw_height_out <= h;
                            if (!head.valid) launched <= launched + 3'd1;
                        end
                        hand_out <= hand;
                        beat_index_out <= beat_idx;
                        hand <= ~hand;
                        beat_idx <= (beat_idx == len - 3'd1) ? 3'd0 : beat_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_juggle_scheduler.sv
// tb_juggle_scheduler: directed checks of the siteswap scheduler.
module tb_juggle_scheduler;
    logic clk_in = 0, rst_in = 1, new_beat = 0, pattern_valid_in = 0;
    logic [6:0][2:0] pattern_in = '0;
    logic [2:0] pattern_length = 0, num_balls_in = 0;
    logic throw_valid_out, hand_out, running_out, error_out;
    logic [2:0] throw_ball_out, throw_height_out, beat_index_out;
    int checks = 0, failures = 0;

    juggle_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .new_beat(new_beat),
        .pattern_in(pattern_in), .pattern_length(pattern_length),
        .num_balls_in(num_balls_in), .pattern_valid_in(pattern_valid_in),
        .throw_valid_out(throw_valid_out), .throw_ball_out(throw_ball_out),
        .throw_height_out(throw_height_out), .hand_out(hand_out),
        .beat_index_out(beat_index_out), .running_out(running_out),
        .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic nb);
        @(negedge clk_in);
        new_beat = nb;
        @(posedge clk_in);
        #1 new_beat = 0;
    endtask

    task automatic load(input logic [2:0] d0, d1, d2, len, balls);
        @(negedge clk_in);
        pattern_in = '0;
        pattern_in[0] = d0;
        pattern_in[1] = d1;
        pattern_in[2] = d2;
        pattern_length = len;
        num_balls_in = balls;
        pattern_valid_in = 1;
        new_beat = 1;
        @(posedge clk_in);
        #1 new_beat = 0;
        chk("capture_running", {7'd0, running_out}, 8'd1);
        chk("capture_no_throw", {7'd0, throw_valid_out}, 8'd0);
    endtask

    task automatic drop;
        @(negedge clk_in);
        pattern_valid_in = 0;
        @(posedge clk_in);
        #1;
        chk("drop_running", {7'd0, running_out}, 8'd0);
        chk("drop_error", {7'd0, error_out}, 8'd0);
    endtask

    task automatic beat(input string tag, input logic tv, input logic [2:0] ball, height,
                        input logic hnd, input logic [2:0] idx);
        tick(1);
        chk({tag, "_valid"}, {7'd0, throw_valid_out}, {7'd0, tv});
        chk({tag, "_ball"}, {5'd0, throw_ball_out}, {5'd0, ball});
        chk({tag, "_height"}, {5'd0, throw_height_out}, {5'd0, height});
        chk({tag, "_hand"}, {7'd0, hand_out}, {7'd0, hnd});
        chk({tag, "_index"}, {5'd0, beat_index_out}, {5'd0, idx});
        chk({tag, "_error"}, {7'd0, error_out}, 8'd0);
    endtask

    initial begin
        logic [2:0] b441 [9];
        logic [2:0] h441 [3];
        b441 = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
        h441 = '{3'd4, 3'd4, 3'd1};
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_outputs", {throw_valid_out, throw_ball_out, throw_height_out, hand_out},
            8'd0);
        chk("reset_status", {beat_index_out, running_out, error_out}, 8'd0);
        @(negedge clk_in);
        rst_in = 0;

        // cascade "3", 3 balls; later pattern edits while valid must be ignored
        load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
        pattern_in = '0;
        num_balls_in = 3'd1;
        for (int i = 0; i < 8; i++)
            beat("cascade", 1, 3'(i % 3), 3'd3, 1'(i % 2), 3'd0);
        tick(0);
        chk("pulse_one_cycle", {7'd0, throw_valid_out}, 8'd0);
        drop();

        // 441, 3 balls
        load(3'd4, 3'd4, 3'd1, 3'd3, 3'd3);
        for (int i = 0; i < 9; i++)
            beat("p441", 1, b441[i], h441[i % 3], 1'(i % 2), 3'(i % 3));
        drop();

        // gap 330, 2 balls: no throw on beat 2, registers hold ball 1 h3
        load(3'd3, 3'd3, 3'd0, 3'd3, 3'd2);
        beat("gap0", 1, 3'd0, 3'd3, 0, 3'd0);
        beat("gap1", 1, 3'd1, 3'd3, 1, 3'd1);
        beat("gap2", 0, 3'd1, 3'd3, 0, 3'd2);
        beat("gap3", 1, 3'd0, 3'd3, 1, 3'd0);
        drop();

        // collision 43, 3 balls
        load(3'd4, 3'd3, 3'd0, 3'd2, 3'd3);
        beat("coll0", 1, 3'd0, 3'd4, 0, 3'd0);
        tick(1);
        chk("coll_error", {7'd0, error_out}, 8'd1);
        chk("coll_no_throw", {7'd0, throw_valid_out}, 8'd0);
        chk("coll_running", {7'd0, running_out}, 8'd0);
        chk("coll_hold", {throw_ball_out, throw_height_out, hand_out, 1'b0}, {3'd0, 3'd4, 2'd0});
        tick(1);
        chk("err_stays", {6'd0, error_out, throw_valid_out}, 8'd2);
        drop();

        // starvation 3, 1 ball
        load(3'd3, 3'd0, 3'd0, 3'd1, 3'd1);
        beat("starve0", 1, 3'd0, 3'd3, 0, 3'd0);
        tick(1);
        chk("starve_error", {7'd0, error_out}, 8'd1);
        chk("starve_no_throw", {7'd0, throw_valid_out}, 8'd0);
        drop();

        // beat coincident with valid falling is ignored
        load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
        beat("pre_exit", 1, 3'd0, 3'd3, 0, 3'd0);
        @(negedge clk_in);
        pattern_valid_in = 0;
        new_beat = 1;
        @(posedge clk_in);
        #1 new_beat = 0;
        chk("exit_wins_valid", {7'd0, throw_valid_out}, 8'd0);
        chk("exit_wins_running", {7'd0, running_out}, 8'd0);

        // restart with "5", 5 balls after a mid-run drop
        load(3'd3, 3'd0, 3'd0, 3'd1, 3'd3);
        beat("mid0", 1, 3'd0, 3'd3, 0, 3'd0);
        beat("mid1", 1, 3'd1, 3'd3, 1, 3'd0);
        drop();
        load(3'd5, 3'd0, 3'd0, 3'd1, 3'd5);
        beat("five0", 1, 3'd0, 3'd5, 0, 3'd0);
        beat("five1", 1, 3'd1, 3'd5, 1, 3'd0);

        // async reset mid-run
        @(negedge clk_in);
        rst_in = 1;
        #1;
        chk("async_rst_outputs", {throw_valid_out, throw_ball_out, throw_height_out, hand_out},
            8'd0);
        chk("async_rst_status", {beat_index_out, running_out, error_out}, 8'd0);
        @(negedge clk_in);
        rst_in = 0;
        tick(0);
        chk("after_rst_recapture", {7'd0, running_out}, 8'd1);
        beat("post_rst", 1, 3'd0, 3'd5, 0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/juggle_scheduler.md
# juggle_scheduler

Beat-driven siteswap throw scheduler. It takes the validated pattern, pattern length and ball count produced by pattern entry. On every `new_beat` it decides which ball is thrown, at what height, and from which hand. It tracks in-flight balls in an 8-deep landing queue and flags landing collisions. Its outputs drive the animation/render path.

## Interface
Parameters:
- `MAX_LEN`, 7: maximum pattern length; also the number of digits in `pattern_in`.
- `MAX_HEIGHT`, 7: maximum throw height; landing queue depth is `MAX_HEIGHT+1`.

Ports:
- `clk_in` input 1: system clock, the only clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `new_beat` input 1: single-cycle beat strobe.
- `pattern_in` input 3 x [6:0]: siteswap digits, index 0 thrown first.
- `pattern_length` input 3: number of digits in use, 1..7.
- `num_balls_in` input 3: ball count, 0..7.
- `pattern_valid_in` input 1: level; high while the pattern is valid.
- `throw_valid_out` output 1: one-cycle pulse when a throw occurs.
- `throw_ball_out` output 3: id of the thrown ball.
- `throw_height_out` output 3: height of the thrown ball.
- `hand_out` output 1: hand for the beat (0 = right, 1 = left).
- `beat_index_out` output 3: pattern position of the beat just scheduled.
- `running_out` output 1: high in RUN.
- `error_out` output 1: high in ERROR.

## Operation
- States:
  - IDLE: landing queue empty, `launched` = 0, `beat_index` = 0, `hand` = 0. If `pattern_valid_in` is high and `pattern_length` ≠ 0, snapshot `pattern_in`, `pattern_length` and `num_balls_in`, then go to RUN.
  - RUN: on each `new_beat`, process one beat (rules below).
  - ERROR: hold every output except `throw_valid_out`, which is 0.
- Leaving RUN or ERROR: when `pattern_valid_in` goes low, return to IDLE and clear the queue. Pattern inputs that change while `pattern_valid_in` stays high are ignored.
- Landing queue: `slot[k]` = {valid, ball id}, meaning the ball that lands k beats from now. Index 0 is the current beat.
- Per-beat processing in RUN, with h = `pattern[beat_index]`:
  - `slot[0]` valid and h = 0: collision, go to ERROR.
  - `slot[0]` valid and h > 0: rethrow ball `slot[0].id`.
  - `slot[0]` empty, h > 0, `launched` < `num_balls`: throw new ball id = `launched`, then `launched`++.
  - `slot[0]` empty, h > 0, `launched` = `num_balls`: starvation, go to ERROR.
  - `slot[0]` empty, h = 0: no throw; `throw_valid_out` stays 0.
  - Collision check: if a throw occurs and pre-shift `slot[h]` is valid, go to ERROR.
  - Queue update: shift down (`slot[i]` ← `slot[i+1]`, top ← empty). The thrown ball is written to post-shift index h-1.
  - Counters: `beat_index` wraps from `pattern_length`-1 to 0. `hand` toggles every beat, including beats with no throw.
- Any ERROR transition suppresses that beat's throw and leaves the queue frozen.

## Timing
- All outputs are registered. Results appear on the cycle after the `new_beat` edge.
- `throw_valid_out` is high for exactly one cycle per throw.
- On the capture cycle, `new_beat` is ignored. The first throw happens on the next `new_beat`.
- A `new_beat` on the same cycle that `pattern_valid_in` falls is ignored; the exit to IDLE wins.
- Reset values: all outputs 0, state IDLE, queue empty.
- Asserting reset mid-RUN immediately returns the block to reset values.
- Worst-case beat processing takes 1 cycle; there is no back-pressure.

## Structure
- `juggle_pkg` holds:
  - `MAX_LEN` and `MAX_HEIGHT`.
  - `slot_t` struct: `logic valid; logic [2:0] id`.
  - `sched_state_t` enum: IDLE, RUN, ERROR.
- Sub-module `landing_queue`:
  - Holds the 8-entry `slot_t` array.
  - Ports: `clear`, `shift`, `wr_en`, `wr_idx`, `wr_id`, plus combinational reads of `slot[0]` and `slot[h]`.
- The FSM, counters and output registers stay in `juggle_scheduler`.

## Test plan
- Cascade: pattern "3", length 1, 3 balls, 8 beats -> balls 0,1,2,0,1,2,0,1, all height 3. `hand_out` alternates 0,1. `error_out` stays 0.
- Pattern "441", 3 balls, 9 beats -> balls 0,1,2,2,0,1,1,2,0 with heights 4,4,1 repeating. `beat_index_out` reads 0,1,2,0,…
- Gap: "330", 2 balls -> beat 0: ball 0 h3; beat 1: ball 1 h3; beat 2: no throw; beat 3: ball 0. Hand still toggles on beat 2.
- Collision: "43", 3 balls -> beat 0: ball 0 h4. On beat 1, `error_out`=1 and `throw_valid_out`=0. Dropping `pattern_valid_in` -> IDLE, `error_out`=0.
- Starvation: "3", 1 ball -> on beat 1, `error_out`=1.
- Restart/reset: deassert `pattern_valid_in` mid-RUN, then reassert with "5", 5 balls -> first throw is ball 0 h5. Asserting `rst_in` mid-RUN -> outputs 0 immediately.
